// File: rtl/fbuf_write_arbiter.sv
// Framebuffer BRAM write-port arbiter: round-robin sharing among NUM_REQ pixel
// writers plus a built-in full-frame clear sequencer, registered one-cycle output.
module fbuf_write_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int FBUF_DEPTH      = 307200
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ*FBUF_ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*FBUF_DATA_WIDTH-1:0]   req_data,
  input  logic                                 clear_start,
  input  logic [FBUF_DATA_WIDTH-1:0]           clear_color,
  output logic                                 clear_busy,
  output logic                                 clear_done,
  output logic                                 oob_error,
  input  logic                                 fbuf_rst_busy,
  output logic                                 fbuf_en_wr,
  output logic                                 fbuf_wrea,
  output logic [FBUF_ADDR_WIDTH-1:0]           fbuf_addr,
  output logic [FBUF_DATA_WIDTH-1:0]           fbuf_data
);
  localparam int AW = FBUF_ADDR_WIDTH;
  localparam int DW = FBUF_DATA_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW-1:0] LAST = AW'(FBUF_DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;       // first requester to consider next
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          oob_q, oob_d;
  logic          done_q, done_d;
  logic          found;
  int            gnt;
  int            idx;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    color_d   = color_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = 1'b0;
    oob_d     = 1'b0;
    done_d    = 1'b0;
    req_ready = '0;
    found     = 1'b0;
    gnt       = 0;
    idx       = 0;
    // A BRAM reset freezes everything, including a pending clear_start.
    if (!rst && !fbuf_rst_busy) begin
      case (state_q)
        S_IDLE: begin
          for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
              found = 1'b1;
              gnt   = idx;
            end
          end
          if (found) begin
            req_ready[gnt] = 1'b1;
            ptr_d = (gnt == NUM_REQ - 1) ? '0 : PW'(gnt + 1);
            if (req_addr[gnt*AW +: AW] > LAST) begin
              oob_d = 1'b1;
            end else begin
              wr_d   = 1'b1;
              addr_d = req_addr[gnt*AW +: AW];
              data_d = req_data[gnt*DW +: DW];
            end
          end
          if (clear_start) begin
            state_d = S_CLEAR;
            color_d = clear_color;
            cnt_d   = '0;
          end
        end
        S_CLEAR: begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          data_d = color_q;
          if (cnt_q == LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      color_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      oob_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      oob_q   <= oob_d;
      done_q  <= done_d;
    end
  end

  assign fbuf_en_wr = wr_q;
  assign fbuf_wrea  = wr_q;
  assign fbuf_addr  = addr_q;
  assign fbuf_data  = data_q;
  assign oob_error  = oob_q;
  assign clear_done = done_q;
  assign clear_busy = (state_q == S_CLEAR);
endmodule

// File: tb/tb_fbuf_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_fbuf_write_arbiter;
  localparam int NR = 2, AW = 5, DW = 8, DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clear_start, fbuf_rst_busy;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [DW-1:0] clear_color, fbuf_data;
  logic [AW-1:0] fbuf_addr;
  logic clear_busy, clear_done, oob_error, fbuf_en_wr, fbuf_wrea;

  fbuf_write_arbiter #(.NUM_REQ(NR), .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW),
                       .FBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .clear_start(clear_start),
    .clear_color(clear_color), .clear_busy(clear_busy), .clear_done(clear_done),
    .oob_error(oob_error), .fbuf_rst_busy(fbuf_rst_busy), .fbuf_en_wr(fbuf_en_wr),
    .fbuf_wrea(fbuf_wrea), .fbuf_addr(fbuf_addr), .fbuf_data(fbuf_data));

  int checks = 0, errs = 0;

  // reference model state
  bit            m_clr;
  int            m_cnt, m_last;
  logic [DW-1:0] m_color, m_data;
  logic [AW-1:0] m_addr;
  logic [NR-1:0] m_ready;

  int wr_log[$], gnt_log[$];
  int n_wr, n_done, n_busy, n_oob;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_logs();
    wr_log.delete(); gnt_log.delete();
    n_wr = 0; n_done = 0; n_busy = 0; n_oob = 0;
  endtask

  // One clock: check the combinational grant, advance the model, check registered outputs.
  task automatic tick();
    logic e_wr, e_oob, e_done;
    int sel;
    #1;
    m_ready = '0; e_wr = 0; e_oob = 0; e_done = 0; sel = -1;
    if (rst) begin
      m_clr = 0; m_last = NR - 1; m_addr = '0; m_data = '0;
    end else if (!fbuf_rst_busy) begin
      if (!m_clr) begin
        for (int k = 1; k <= NR; k++) begin
          int i;
          i = (m_last + k) % NR;
          if (sel < 0 && req_valid[i]) sel = i;
        end
        if (sel >= 0) begin
          m_ready[sel] = 1'b1;
          m_last = sel;
          if (int'(req_addr[sel*AW +: AW]) >= DEPTH) e_oob = 1;
          else begin
            e_wr = 1; m_addr = req_addr[sel*AW +: AW]; m_data = req_data[sel*DW +: DW];
          end
        end
        if (clear_start) begin m_clr = 1; m_cnt = 0; m_color = clear_color; end
      end else begin
        e_wr = 1; m_addr = AW'(m_cnt); m_data = m_color;
        if (m_cnt == DEPTH - 1) begin m_clr = 0; e_done = 1; end
        else m_cnt++;
      end
    end
    chk("req_ready", 64'(req_ready), 64'(m_ready));
    for (int i = 0; i < NR; i++) if (req_ready[i]) gnt_log.push_back(i);
    @(posedge clk); #1;
    chk("fbuf_en_wr", 64'(fbuf_en_wr), 64'(e_wr));
    chk("fbuf_wrea", 64'(fbuf_wrea), 64'(e_wr));
    chk("oob_error", 64'(oob_error), 64'(e_oob));
    chk("clear_done", 64'(clear_done), 64'(e_done));
    chk("clear_busy", 64'(clear_busy), 64'(m_clr));
    chk("fbuf_addr", 64'(fbuf_addr), 64'(m_addr));
    chk("fbuf_data", 64'(fbuf_data), 64'(m_data));
    if (fbuf_en_wr) begin n_wr++; wr_log.push_back(int'(fbuf_addr)); end
    if (clear_done) n_done++;
    if (clear_busy) n_busy++;
    if (oob_error) n_oob++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  initial begin
    int n0;
    bit pend [NR];
    rst = 1; clear_start = 0; clear_color = '0; fbuf_rst_busy = 0;
    req_valid = '0; req_addr = '0; req_data = '0;
    m_clr = 0; m_last = NR - 1; m_cnt = 0; m_color = '0; m_addr = '0; m_data = '0;
    clr_logs();

    // reset held with both requesters asking
    set_req(0, 1, 10, 8'h11); set_req(1, 1, 13, 8'h22);
    run(3);
    chk("rst_no_grant", 64'(gnt_log.size()), 64'd0);
    chk("rst_no_write", 64'(n_wr), 64'd0);

    // fairness: 0,1,0,1,0,1
    rst = 0; clr_logs();
    run(6);
    chk("fair_cnt", 64'(gnt_log.size()), 64'd6);
    for (int j = 0; j < 6 && j < gnt_log.size(); j++) begin
      chk("fair_gnt", 64'(gnt_log[j]), 64'(j % 2));
      chk("fair_addr", 64'(wr_log[j]), (j % 2) ? 64'd13 : 64'd10);
    end
    req_valid = '0;
    run(1);

    // full clear with A5
    clr_logs();
    clear_start = 1; clear_color = 8'hA5;
    tick();
    clear_start = 0; clear_color = 8'h00;
    run(20);
    chk("clr_writes", 64'(n_wr), 64'd16);
    chk("clr_done", 64'(n_done), 64'd1);
    chk("clr_busy", 64'(n_busy), 64'd16);
    for (int j = 0; j < 16 && j < wr_log.size(); j++) chk("clr_addr", 64'(wr_log[j]), 64'(j));

    // stall for 5 cycles at counter 7
    clr_logs();
    clear_start = 1; clear_color = 8'h3C;
    tick();
    clear_start = 0;
    run(7);
    chk("stall_pre", 64'(n_wr), 64'd7);
    fbuf_rst_busy = 1;
    n0 = n_wr;
    run(5);
    chk("stall_nowr", 64'(n_wr), 64'(n0));
    fbuf_rst_busy = 0;
    run(15);
    chk("stall_total", 64'(n_wr), 64'd16);
    chk("stall_resume", 64'(wr_log[7]), 64'd7);
    chk("stall_done", 64'(n_done), 64'd1);

    // out-of-range request, then the next one goes through
    clr_logs();
    set_req(0, 1, DEPTH, 8'h44);
    tick();
    chk("oob_ready", 64'(gnt_log.size()), 64'd1);
    chk("oob_nowr", 64'(n_wr), 64'd0);
    chk("oob_pulse", 64'(n_oob), 64'd1);
    set_req(0, 1, 5, 8'h55); set_req(1, 1, 6, 8'h66);
    tick();
    req_valid = '0;
    run(1);
    chk("oob_next_gnt", 64'(gnt_log[gnt_log.size()-1]), 64'd1);
    chk("oob_next_wr", 64'(n_wr), 64'd1);
    chk("oob_once", 64'(n_oob), 64'd1);

    // collision with clear_start, then reset at counter 5
    clr_logs();
    set_req(1, 1, 9, 8'h77);
    clear_start = 1; clear_color = 8'h5A;
    tick();
    set_req(1, 0, 9, 8'h77); clear_start = 0;
    run(5);
    chk("col_first", 64'(wr_log[0]), 64'd9);
    chk("col_clear0", 64'(wr_log[1]), 64'd0);
    rst = 1;
    tick();
    chk("abort_busy", 64'(clear_busy), 64'd0);
    rst = 0;
    run(20);
    chk("abort_nodone", 64'(n_done), 64'd0);

    // random traffic; requesters hold until accepted
    for (int i = 0; i < NR; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!pend[i] && ($urandom % 3 == 0)) begin
          pend[i] = 1;
          set_req(i, 1, $urandom_range(0, 20), $urandom);
        end
      clear_start = ($urandom % 40 == 0);
      clear_color = DW'($urandom);
      fbuf_rst_busy = ($urandom % 8 == 0);
      tick();
      for (int i = 0; i < NR; i++)
        if (m_ready[i]) begin pend[i] = 0; req_valid[i] = 0; end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
